// File: rtl/axi_slave_wr_if.sv
// AW/W/B channel bundle between an AXI4 write master and the axi_slave_wr responder.
interface axi_slave_wr_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_slave_wr.sv
// AXI4 write responder: takes one INCR burst at a time into a byte-strobed word memory
// and answers with one B response per burst; a registered debug port reads the memory.
module axi_slave_wr #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axi_slave_wr_if.slave            axi,
    input  logic                     dbg_rd_en,
    input  logic [$clog2(DEPTH)-1:0] dbg_rd_addr,
    output logic [DATA_W-1:0]        dbg_rd_data
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int NB    = DATA_W / 8;

    // S_DONE is the idle cycle between the last beat and bvalid.
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_DONE, S_RESP} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [DATA_W-1:0] dbg_rd_data_q, dbg_rd_data_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic in_range;
    logic beat;
    logic last_beat;
    logic mem_we;

    // No wrap: any index bit at or above IDX_W means the beat is beyond the memory.
    assign in_range  = (idx_q >> IDX_W) == '0;
    assign beat      = (state_q == S_DATA) && axi.wvalid && wready_q;
    assign last_beat = axi.wlast || (cnt_q == len_q);
    assign mem_we    = beat && in_range;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        dbg_rd_data_d = dbg_rd_en ? mem[dbg_rd_addr] : dbg_rd_data_q;

        case (state_q)
            S_IDLE: begin
                if (axi.awvalid && awready_q) begin
                    idx_d   = (axi.awaddr - BASE_ADDR) >> OFF_W;
                    len_d   = axi.awlen;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (beat) begin
                    if (!in_range) err_d = 1'b1;
                    idx_d = idx_q + ADDR_W'(1);
                    cnt_d = cnt_q + 8'd1;
                    if (last_beat) begin
                        if (axi.wlast != (cnt_q == len_q)) err_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_RESP;
            S_RESP: begin
                if (bvalid_q && axi.bready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake outputs follow the next state so they are registered yet cycle-exact.
        awready_d = (state_d == S_IDLE);
        wready_d  = (state_d == S_DATA);
        bvalid_d  = (state_d == S_RESP);
        bresp_d   = (state_d == S_RESP && err_d) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= 2'b00;
            dbg_rd_data_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            dbg_rd_data_q <= dbg_rd_data_d;
        end
    end

    // NOTE: the memory array has no reset so it maps onto RAM and survives a mid-burst reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (axi.wstrb[b]) mem[idx_q[IDX_W-1:0]][b*8 +: 8] <= axi.wdata[b*8 +: 8];
            end
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign dbg_rd_data = dbg_rd_data_q;
endmodule

// File: tb/tb_axi_slave_wr.sv
// Scoreboard bench for axi_slave_wr: expected B responses queued at stimulus time,
// memory contents tracked by a byte-strobe model and checked through the debug port.
module tb_axi_slave_wr;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int IDX_W  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_slave_wr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic              dbg_rd_en = 1'b0;
    logic [IDX_W-1:0]  dbg_rd_addr = '0;
    logic [DATA_W-1:0] dbg_rd_data;

    axi_slave_wr #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR('0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .axi(bus),
        .dbg_rd_en(dbg_rd_en), .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  sb[$];
    logic [31:0] model_mem [DEPTH];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_apply(input int idx, input logic [31:0] data, input logic [3:0] strb);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    task automatic aw_hs(input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        bus.awaddr = addr; bus.awlen = len; bus.awvalid = 1'b1;
        while (bus.awready !== 1'b1 && n < 20) begin tick(); n++; end
        if (bus.awready !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL aw_timeout: awready=%b required 1", bus.awready);
        end
        tick();
        bus.awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        while (bus.wready !== 1'b1 && n < 20) begin tick(); n++; end
        if (bus.wready !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL w_timeout: wready=%b required 1", bus.wready);
        end
        tick();
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic b_take(output logic [1:0] got, output logic [1:0] exp);
        int n = 0;
        bus.bready = 1'b1;
        while (bus.bvalid !== 1'b1 && n < 20) begin tick(); n++; end
        if (bus.bvalid !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL b_timeout: bvalid=%b required 1", bus.bvalid);
        end
        got = bus.bresp;
        exp = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic dbg_read(input int idx, output logic [31:0] data);
        dbg_rd_en = 1'b1; dbg_rd_addr = IDX_W'(idx);
        tick();
        dbg_rd_en = 1'b0;
        data = dbg_rd_data;
    endtask

    task automatic write_burst(input logic [31:0] addr, input int len, input int nbeats,
                               input logic [31:0] base, input logic [3:0] strb,
                               input bit give_wlast);
        int idx;
        bit err;
        idx = int'(addr >> 2);
        err = !(give_wlast && (nbeats - 1 == len));
        for (int i = 0; i < nbeats; i++) if (idx + i >= DEPTH) err = 1'b1;
        sb.push_back(err ? 2'b10 : 2'b00);
        aw_hs(addr, 8'(len));
        for (int i = 0; i < nbeats; i++) begin
            w_beat(base + 32'(i), strb, give_wlast && (i == nbeats - 1));
            if (idx + i < DEPTH) model_apply(idx + i, base + 32'(i), strb);
        end
    endtask

    task automatic test_reset();
        logic [1:0] got_b;
        tick(); tick();
        n_cmp++; if (bus.awready !== 1'b0) begin n_err++; $display("FAIL rst_awready: got %b want 0", bus.awready); end
        n_cmp++; if (bus.wready !== 1'b0) begin n_err++; $display("FAIL rst_wready: got %b want 0", bus.wready); end
        n_cmp++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL rst_bvalid: got %b want 0", bus.bvalid); end
        got_b = bus.bresp;
        n_cmp++; if (got_b !== 2'b00) begin n_err++; $display("FAIL rst_bresp: got %b want 00", got_b); end
        n_cmp++; if (dbg_rd_data !== 32'h0) begin n_err++; $display("FAIL rst_dbg: got %h want 0", dbg_rd_data); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.awready !== 1'b1) begin n_err++; $display("FAIL rst_release_awready: got %b want 1", bus.awready); end
    endtask

    task automatic test_single();
        logic [1:0] got, exp;
        logic [31:0] d;
        write_burst(32'h10, 0, 1, 32'hDEADBEEF, 4'hF, 1'b1);
        b_take(got, exp);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL single_bresp: got %b want %b", got, exp); end
        dbg_read(4, d);
        n_cmp++; if (d !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_mem4: got %h want deadbeef", d); end
    endtask

    task automatic test_burst();
        logic [1:0] got, exp;
        logic [31:0] d;
        write_burst(32'h40, 3, 4, 32'd1, 4'hF, 1'b1);
        n_cmp++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL burst_bvalid_gap: got %b want 0", bus.bvalid); end
        n_cmp++; if (bus.wready !== 1'b0) begin n_err++; $display("FAIL burst_wready_after: got %b want 0", bus.wready); end
        tick();
        n_cmp++; if (bus.bvalid !== 1'b1) begin n_err++; $display("FAIL burst_bvalid_lat: got %b want 1", bus.bvalid); end
        b_take(got, exp);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL burst_bresp: got %b want %b", got, exp); end
        n_cmp++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL burst_bvalid_drop: got %b want 0", bus.bvalid); end
        n_cmp++; if (bus.awready !== 1'b1) begin n_err++; $display("FAIL burst_next_aw: got %b want 1", bus.awready); end
        for (int i = 16; i < 20; i++) begin
            dbg_read(i, d);
            n_cmp++; if (d !== model_mem[i]) begin n_err++; $display("FAIL burst_mem%0d: got %h want %h", i, d, model_mem[i]); end
        end
    endtask

    task automatic test_strobes();
        logic [1:0] got, exp;
        logic [31:0] d;
        write_burst(32'h0, 0, 1, 32'hFFFFFFFF, 4'hF, 1'b1);
        b_take(got, exp);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL strb_fill_bresp: got %b want %b", got, exp); end
        write_burst(32'h0, 0, 1, 32'h12345678, 4'b0101, 1'b1);
        b_take(got, exp);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL strb_bresp: got %b want %b", got, exp); end
        dbg_read(0, d);
        n_cmp++; if (d !== 32'hFF34FF78) begin n_err++; $display("FAIL strb_mem0: got %h want ff34ff78", d); end
    endtask

    task automatic test_errors();
        logic [1:0] got, exp;
        logic [31:0] d;
        write_burst(32'h100, 3, 2, 32'hC000_0000, 4'hF, 1'b1);
        n_cmp++; if (bus.wready !== 1'b0) begin n_err++; $display("FAIL early_wready: got %b want 0", bus.wready); end
        b_take(got, exp);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL early_bresp: got %b want %b", got, exp); end
        write_burst(32'h200, 0, 1, 32'h0BAD_F00D, 4'hF, 1'b1);
        b_take(got, exp);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL after_err_bresp: got %b want %b", got, exp); end
        write_burst(32'h300, 1, 2, 32'h7700_0000, 4'hF, 1'b0);
        b_take(got, exp);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL no_wlast_bresp: got %b want %b", got, exp); end
        write_burst(32'h3FC, 1, 2, 32'hAB00_0000, 4'hF, 1'b1);
        b_take(got, exp);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL oor_bresp: got %b want %b", got, exp); end
        dbg_read(255, d);
        n_cmp++; if (d !== model_mem[255]) begin n_err++; $display("FAIL oor_mem255: got %h want %h", d, model_mem[255]); end
        dbg_read(0, d);
        n_cmp++; if (d !== model_mem[0]) begin n_err++; $display("FAIL oor_nowrap_mem0: got %h want %h", d, model_mem[0]); end
        dbg_read(65, d);
        n_cmp++; if (d !== model_mem[65]) begin n_err++; $display("FAIL early_mem65: got %h want %h", d, model_mem[65]); end
    endtask

    task automatic test_backpressure();
        logic [1:0] got, exp;
        int n = 0;
        write_burst(32'h180, 3, 2, 32'h5500_0000, 4'hF, 1'b1);
        while (bus.bvalid !== 1'b1 && n < 10) begin tick(); n++; end
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (bus.bvalid !== 1'b1) begin n_err++; $display("FAIL bp_bvalid c%0d: got %b want 1", c, bus.bvalid); end
            got = bus.bresp;
            n_cmp++; if (got !== 2'b10) begin n_err++; $display("FAIL bp_bresp c%0d: got %b want 10", c, got); end
            n_cmp++; if (bus.awready !== 1'b0) begin n_err++; $display("FAIL bp_awready c%0d: got %b want 0", c, bus.awready); end
            tick();
        end
        b_take(got, exp);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL bp_final_bresp: got %b want %b", got, exp); end
    endtask

    task automatic test_read_during_write();
        logic [1:0] got, exp;
        logic [31:0] d, old;
        write_burst(32'h22, 0, 1, 32'h11111111, 4'hF, 1'b1);
        b_take(got, exp);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL unaligned_bresp: got %b want %b", got, exp); end
        old = model_mem[8];
        sb.push_back(2'b00);
        aw_hs(32'h20, 8'd0);
        dbg_rd_en = 1'b1; dbg_rd_addr = 8'd8;
        w_beat(32'h22222222, 4'hF, 1'b1);
        dbg_rd_en = 1'b0;
        model_apply(8, 32'h22222222, 4'hF);
        d = dbg_rd_data;
        n_cmp++; if (d !== old) begin n_err++; $display("FAIL rdw_old: got %h want %h", d, old); end
        b_take(got, exp);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rdw_bresp: got %b want %b", got, exp); end
        dbg_read(8, d);
        n_cmp++; if (d !== model_mem[8]) begin n_err++; $display("FAIL rdw_new: got %h want %h", d, model_mem[8]); end
        dbg_rd_addr = 8'd16;
        tick();
        n_cmp++; if (dbg_rd_data !== model_mem[8]) begin n_err++; $display("FAIL dbg_hold: got %h want %h", dbg_rd_data, model_mem[8]); end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] d;
        aw_hs(32'h80, 8'd3);
        w_beat(32'hA5A5A5A5, 4'hF, 1'b0);
        model_apply(32, 32'hA5A5A5A5, 4'hF);
        rst_n = 1'b0;
        #2;
        n_cmp++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL midrst_bvalid: got %b want 0", bus.bvalid); end
        n_cmp++; if (bus.wready !== 1'b0) begin n_err++; $display("FAIL midrst_wready: got %b want 0", bus.wready); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.awready !== 1'b1) begin n_err++; $display("FAIL midrst_awready: got %b want 1", bus.awready); end
        n_cmp++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL midrst_no_b: got %b want 0", bus.bvalid); end
        dbg_read(32, d);
        n_cmp++; if (d !== model_mem[32]) begin n_err++; $display("FAIL midrst_mem32: got %h want %h", d, model_mem[32]); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
    endtask

    initial begin
        bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_strobes();
        test_errors();
        test_backpressure();
        test_read_during_write();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
